sv_bus_rr_arbiter: RTL
======================

Name: sv_bus_rr_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit address/data input bus of the bus mux/demux wrapper between N bus sources.
- Sits between the N requesters and the wrapper's input bus port, and sequences which source may transfer.
- Each source uses the same vld/rdy protocol as the wrapper. A transfer happens only when vld and rdy are both high.
- A grant is held across back-to-back transfers, up to a burst limit, before it rotates to the next source.

Parameters:
- N, 4, number of requesters (1..16)
- AW, 32, address width
- DW, 32, data width
- BST, 4, max consecutive transfers per grant while other requesters wait (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_vld  input  N  per-requester valid
- req_adr  input  N*AW  packed addresses; requester i occupies bits [i*AW +: AW]
- req_dat  input  N*DW  packed data; requester i occupies bits [i*DW +: DW]
- req_rdy  output  N  per-requester ready
- bus_vld  output  1  valid to the mux input bus
- bus_adr  output  AW  address to the mux input bus
- bus_dat  output  DW  data to the mux input bus
- bus_rdy  input  1  ready from the mux input bus
- gnt  output  N  one-hot grant, registered
- gnt_idx  output  max(1,$clog2(N))  index of the granted requester, registered

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, gnt=0, gnt_idx=0, ptr=0, cnt=0.
- Reset forces bus_vld=0, bus_adr=0, bus_dat=0 and req_rdy=0 immediately, with no clock needed.
- Source protocol: once req_vld[i]=1, the source holds req_vld/adr/dat stable until its transfer. The arbiter relies on this rule.
- Registered state: state {IDLE, GRANT}, g (granted index), ptr (round-robin start), cnt (transfers in current grant, width $clog2(BST)+1).
- Arbitration function: winner = first i with req_vld[i]=1, scanning ptr, ptr+1, ... mod N.
- IDLE outputs: gnt=0, bus_vld=0, bus_adr/bus_dat=0, req_rdy=0.
- IDLE transitions: at a clock edge with any req_vld=1, go to GRANT with g=winner, gnt one-hot, cnt=0.
- IDLE latency: req_vld rising leads to bus_vld=1 one cycle later.
- GRANT outputs (combinational passthrough, zero cycle latency):
  - bus_vld=req_vld[g], bus_adr=req_adr[g], bus_dat=req_dat[g].
  - req_rdy[g]=bus_rdy; all other req_rdy=0.
- Transfer: xfer = req_vld[g] & bus_rdy. At most one transfer per cycle.
- GRANT transitions, evaluated at each clock edge, first match wins:
  - a) req_vld[g]=0 (requester idle): release.
  - b) xfer and cnt==BST-1 and another requester has vld: release.
  - c) xfer and cnt==BST-1 and no other requester has vld: keep g, cnt=0.
  - d) xfer otherwise: cnt=cnt+1.
  - e) otherwise: hold.
- Release:
  - ptr=(g+1) mod N.
  - Arbitrate over req_vld with bit g masked, starting at (g+1) mod N.
  - If a winner exists, go directly to GRANT for it with cnt=0 (no bubble cycle). Else go to IDLE.
- Fairness: with all N requesters continuously valid, each receives exactly BST transfers in turn. No requester waits more than (N-1)*BST transfers.
- BST=1: the grant rotates after every transfer when others are waiting.
- N=1: the only requester is always the winner; gnt_idx=0; the burst limit never forces release.
- Wrap-around: ptr and the scan wrap modulo N. cnt never exceeds BST-1.
- Reset mid-transfer: the arbiter aborts the transfer and drops outputs immediately. After reset deasserts, arbitration restarts from ptr=0.

Test Plan:
- Single source: N=4, BST=4. Requester 2 issues 10 transfers, bus_rdy=1.
  - bus_vld rises 1 cycle after req_vld[2].
  - gnt=4'b0100 throughout; 10 transfers back-to-back with no rotation.
  - bus_adr/bus_dat equal req_adr[2]/req_dat[2] on every transfer.
- All four sources continuously valid, bus_rdy=1, BST=4.
  - Grant order 0,1,2,3,0...; each grant lasts exactly 4 transfers.
  - Handover has no idle cycle; 32 transfers complete in 33 cycles.
- BST=1, requesters 1 and 3 continuously valid.
  - Transfers alternate 1,3,1,3.
  - req_rdy is never high for a non-granted requester.
- Backpressure: toggle bus_rdy 1,0,0,1 with requester 0 granted.
  - Grant is held; cnt advances only on cycles where bus_rdy=1.
  - Address/data remain stable while bus_rdy=0.
- Requester 1 drops vld after 2 transfers while requester 2 is waiting.
  - Next cycle gnt=4'b0100; ptr=2.
- Loopback check: 4 sources, each sending 10 random address/data pairs through the arbiter, mux and demux.
  - All 40 pairs arrive at the demux output matching.
- Reset: assert rst mid-burst.
  - bus_vld=0 and gnt=0 within the same cycle, with no clock edge needed.
  - After release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/sv_bus_rr_arbiter.sv
// Round-robin arbiter: N vld/rdy sources share one address/data bus, grant held for up to BST transfers.
// Grant is registered (bus_vld one cycle after first request); granted data/ready pass through combinationally.
module sv_bus_rr_arbiter #(
   parameter int N   = 4,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int BST = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1,
   localparam int CW = $clog2(BST) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_vld,
   input  logic [N*AW-1:0] req_adr,
   input  logic [N*DW-1:0] req_dat,
   output logic [N-1:0]    req_rdy,
   output logic            bus_vld,
   output logic [AW-1:0]   bus_adr,
   output logic [DW-1:0]   bus_dat,
   input  logic            bus_rdy,
   output logic [N-1:0]    gnt,
   output logic [IW-1:0]   gnt_idx
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] g_q, g_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  gnt_q, gnt_d;

   logic [N-1:0]  others;
   logic          xfer, last;
   logic          w_any, r_any;
   logic [IW-1:0] w_idx, r_idx;

   function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
      return (int'(i) == N - 1) ? '0 : IW'(i + 1'b1);
   endfunction

   // Returns {found, index} of the first set bit of v, scanning upward from start with wrap.
   function automatic logic [IW:0] pick(input logic [N-1:0] v, input logic [IW-1:0] start);
      logic [IW-1:0] idx;
      logic [IW-1:0] win;
      logic          found;
      idx   = start;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && v[idx]) begin
            found = 1'b1;
            win   = idx;
         end
         idx = inc_idx(idx);
      end
      return {found, win};
   endfunction

   always_comb begin
      bus_vld = 1'b0;
      bus_adr = '0;
      bus_dat = '0;
      req_rdy = '0;
      if (state_q == GRANT) begin
         bus_vld      = req_vld[g_q];
         bus_adr      = req_adr[int'(g_q)*AW +: AW];
         bus_dat      = req_dat[int'(g_q)*DW +: DW];
         req_rdy[g_q] = bus_rdy;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = g_q;

   always_comb begin
      others         = req_vld & ~(N'(1) << g_q);
      xfer           = req_vld[g_q] & bus_rdy;
      last           = (cnt_q == CW'(BST - 1));
      {w_any, w_idx} = pick(req_vld, ptr_q);
      {r_any, r_idx} = pick(others, inc_idx(g_q));

      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (w_any) begin
               state_d = GRANT;
               g_d     = w_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (!req_vld[g_q] || (xfer && last && (|others))) begin
               // Release: hand over straight to the next waiting source, no bubble.
               ptr_d = inc_idx(g_q);
               cnt_d = '0;
               if (r_any) begin
                  g_d = r_idx;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer && last) begin
               cnt_d = '0;
            end else if (xfer) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      gnt_d = (state_d == GRANT) ? (N'(1) << g_d) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
      end
   end

endmodule
